// File: rtl/ahb_pkg.sv
// Shared AHB encodings for the arbiter slice.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int MAX_MASTERS = 16;
endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr+1, wrapping.
module ahb_rr_picker import ahb_pkg::*; #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [3:0]             i_ptr,
  output logic [NUM_MASTERS-1:0] o_onehot,
  output logic [3:0]             o_idx,
  output logic                   o_any
);
  logic [NUM_MASTERS-1:0] w_rot;
  int                     w_sel;

  // Rotate so bit 0 is the master just after the pointer.
  assign w_rot = NUM_MASTERS'({i_req, i_req} >> (5'(i_ptr) + 5'd1));

  always_comb begin
    o_any    = 1'b0;
    o_onehot = '0;
    w_sel    = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        w_sel = (int'(i_ptr) + 1 + k) % NUM_MASTERS;
      end
    end
    o_idx = 4'(w_sel);
    for (int m = 0; m < NUM_MASTERS; m++) o_onehot[m] = o_any && (m == w_sel);
  end
endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with HLOCK hold and SPLIT masking,
// plus address/data-phase owner tracking for the bus muxes.
module ahb_arbiter import ahb_pkg::*; #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NUM_MASTERS-1:0]   hbusreq,
  input  logic [NUM_MASTERS-1:0]   hlock,
  input  logic [1:0]               htrans,
  input  logic                     hready,
  input  logic [1:0]               hresp,
  input  logic [16*NUM_SLAVES-1:0] hsplit_all,
  output logic [NUM_MASTERS-1:0]   hgrant,
  output logic [3:0]               hmaster,
  output logic [3:0]               hmaster_data,
  output logic                     hmastlock
);
  localparam logic [3:0]             DEF_IDX = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant, r_mask;
  logic [3:0]             r_master, r_mdata, r_ptr;
  logic                   r_mastlock, r_force;

  logic [NUM_MASTERS-1:0] w_elig, w_pick_oh, w_unsplit, w_set;
  logic [3:0]             w_pick_idx, w_gidx;
  logic                   w_pick_any, w_glock, w_greq, w_gmask, w_mreq;
  logic                   w_split_first, w_arb, w_keep, w_unused_split;

  assign w_split_first  = (hresp == HRESP_SPLIT) && !hready;
  assign w_unused_split = ^hsplit_all;

  always_comb begin
    w_gidx  = '0;
    w_glock = 1'b0;
    w_greq  = 1'b0;
    w_gmask = 1'b0;
    w_mreq  = 1'b0;
    w_set   = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (r_grant[m]) begin
        w_gidx  = 4'(m);
        w_glock = hlock[m];
        w_greq  = hbusreq[m];
        w_gmask = r_mask[m];
      end
      if (r_master == 4'(m)) w_mreq = hbusreq[m];
      w_set[m] = w_split_first && (r_mdata == 4'(m)) && (4'(m) != DEF_IDX);
    end
  end

  always_comb begin
    w_unsplit = '0;
    for (int s = 0; s < NUM_SLAVES; s++)
      for (int m = 0; m < NUM_MASTERS; m++)
        w_unsplit[m] = w_unsplit[m] | hsplit_all[16*s + m];
  end

  assign w_elig = hbusreq & ~r_mask;
  // A locked owner mid-burst blocks arbitration; a fresh SPLIT forces it.
  assign w_arb  = (hready && (htrans != HTRANS_SEQ) && !(r_mastlock && w_mreq)) || r_force;
  assign w_keep = w_glock && w_greq && !w_gmask;

  ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .i_req    (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_grant    <= DEF_OH;
      r_master   <= DEF_IDX;
      r_mdata    <= DEF_IDX;
      r_mastlock <= 1'b0;
      r_mask     <= '0;
      r_ptr      <= DEF_IDX;
      r_force    <= 1'b0;
    end else begin
      r_force <= w_split_first;
      // Set beats a same-cycle release of the same master.
      r_mask  <= (r_mask & ~w_unsplit) | w_set;
      if (w_arb && !w_keep) begin
        r_grant <= w_pick_any ? w_pick_oh : DEF_OH;
        // Pointer only follows real winners, not the idle fallback.
        if (w_pick_any) r_ptr <= w_pick_idx;
      end
      if (hready) begin
        r_master   <= w_gidx;
        r_mastlock <= w_glock;
        r_mdata    <= r_master;
      end
    end
  end

  assign hgrant       = r_grant;
  assign hmaster      = r_master;
  assign hmaster_data = r_mdata;
  assign hmastlock    = r_mastlock;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter: hand-derived expected outputs queued per step.
module tb_ahb_arbiter;
  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10;
  localparam logic [1:0] OK = 2'b00, SPL = 2'b11;

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  lk;
    logic [1:0]  tr;
    logic        rdy;
    logic [1:0]  rsp;
    logic [47:0] spl;
    logic [10:0] exp;
  } step_t;

  logic        hclk = 1'b0, hresetn = 1'b0;
  logic [1:0]  hbusreq = '0, hlock = '0, htrans = IDLE, hresp = OK;
  logic        hready = 1'b1;
  logic [47:0] hsplit_all = '0;
  logic [1:0]  hgrant;
  logic [3:0]  hmaster, hmaster_data;
  logic        hmastlock;
  logic [10:0] w_obs, want;
  logic [10:0] sb[$];
  int          n_run = 0, n_fail = 0;

  ahb_arbiter #(.NUM_MASTERS(2), .NUM_SLAVES(3), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hready(hready), .hresp(hresp), .hsplit_all(hsplit_all),
    .hgrant(hgrant), .hmaster(hmaster), .hmaster_data(hmaster_data),
    .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;
  assign w_obs = {hgrant, hmaster, hmaster_data, hmastlock};

  function automatic step_t mk(logic [1:0] req, logic [1:0] lk, logic [1:0] tr,
                               logic rdy, logic [1:0] rsp, logic [47:0] spl,
                               logic [1:0] g, int hm, int hmd, logic ml);
    mk = {req, lk, tr, rdy, rsp, spl, g, 4'(hm), 4'(hmd), ml};
  endfunction

  task automatic drive(input step_t s);
    hbusreq = s.req; hlock = s.lk; htrans = s.tr;
    hready = s.rdy; hresp = s.rsp; hsplit_all = s.spl;
    sb.push_back(s.exp);
  endtask

  task automatic test_reset();
    n_run++;
    if (w_obs !== 11'b01_0000_0000_0) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", w_obs, 11'b01_0000_0000_0);
    end
    @(posedge hclk); #1 hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(mk(2'b00, 2'b00, IDLE, 1'b1, OK, '0, 2'b01, 0, 0, 1'b0));
      @(posedge hclk); #1;
      want = sb.pop_front(); n_run++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL reset_idle[%0d]: got %b want %b", i, w_obs, want);
      end
    end
  endtask

  task automatic test_rr();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive(mk(2'b11, 2'b00, NSEQ, 1'b1, OK, '0, 2'b10, 0, (i == 0) ? 0 : 1, 1'b0));
      else            drive(mk(2'b11, 2'b00, NSEQ, 1'b1, OK, '0, 2'b01, 1, 0, 1'b0));
      @(posedge hclk); #1;
      want = sb.pop_front(); n_run++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL rr_alternate[%0d]: got %b want %b", i, w_obs, want);
      end
    end
  endtask

  task automatic test_lock();
    step_t v[$];
    v.push_back(mk(2'b11, 2'b10, NSEQ, 1'b1, OK, '0, 2'b10, 0, 1, 1'b0));
    v.push_back(mk(2'b11, 2'b10, NSEQ, 1'b1, OK, '0, 2'b10, 1, 0, 1'b1));
    for (int i = 0; i < 4; i++) v.push_back(mk(2'b11, 2'b10, NSEQ, 1'b1, OK, '0, 2'b10, 1, 1, 1'b1));
    v.push_back(mk(2'b11, 2'b00, NSEQ, 1'b1, OK, '0, 2'b10, 1, 1, 1'b0));
    v.push_back(mk(2'b11, 2'b00, NSEQ, 1'b1, OK, '0, 2'b01, 1, 1, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge hclk); #1;
      want = sb.pop_front(); n_run++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL lock_hold[%0d]: got %b want %b", i, w_obs, want);
      end
    end
  endtask

  task automatic test_hready_stall();
    step_t v[$];
    v.push_back(mk(2'b11, 2'b00, NSEQ, 1'b1, OK, '0, 2'b10, 0, 1, 1'b0));
    for (int i = 0; i < 3; i++) v.push_back(mk(2'b11, 2'b00, NSEQ, 1'b0, OK, '0, 2'b10, 0, 1, 1'b0));
    v.push_back(mk(2'b11, 2'b00, NSEQ, 1'b1, OK, '0, 2'b01, 1, 0, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge hclk); #1;
      want = sb.pop_front(); n_run++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL hready_stall[%0d]: got %b want %b", i, w_obs, want);
      end
    end
  endtask

  task automatic test_split();
    step_t v[$];
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b10, 0, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b10, 1, 0, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b10, 1, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b0, SPL, '0, 2'b10, 1, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, IDLE, 1'b1, SPL, '0, 2'b01, 1, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b01, 0, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b01, 0, 0, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  48'h2 << 32, 2'b01, 0, 0, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b10, 0, 0, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge hclk); #1;
      want = sb.pop_front(); n_run++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL split_mask[%0d]: got %b want %b", i, w_obs, want);
      end
    end
  endtask

  task automatic test_split_race();
    step_t v[$];
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b10, 1, 0, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b10, 1, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b0, SPL, 48'h2, 2'b10, 1, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, IDLE, 1'b1, SPL, '0, 2'b01, 1, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b01, 0, 1, 1'b0));
    v.push_back(mk(2'b10, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b01, 0, 0, 1'b0));
    // SPLIT against the default master must leave its eligibility alone.
    v.push_back(mk(2'b01, 2'b00, NSEQ, 1'b0, SPL, '0, 2'b01, 0, 0, 1'b0));
    v.push_back(mk(2'b01, 2'b00, IDLE, 1'b1, SPL, '0, 2'b01, 0, 0, 1'b0));
    v.push_back(mk(2'b11, 2'b00, NSEQ, 1'b1, OK,  48'h2 << 16, 2'b01, 0, 0, 1'b0));
    v.push_back(mk(2'b11, 2'b00, NSEQ, 1'b1, OK,  '0, 2'b10, 0, 0, 1'b0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge hclk); #1;
      want = sb.pop_front(); n_run++;
      if (w_obs !== want) begin
        n_fail++; $display("FAIL split_race[%0d]: got %b want %b", i, w_obs, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    #2 hresetn = 1'b0;
    #1; n_run++;
    if (w_obs !== 11'b01_0000_0000_0) begin
      n_fail++; $display("FAIL reset_async: got %b want %b", w_obs, 11'b01_0000_0000_0);
    end
    @(posedge hclk); #1 hresetn = 1'b1;
    drive(mk(2'b10, 2'b00, NSEQ, 1'b1, OK, '0, 2'b10, 0, 0, 1'b0));
    @(posedge hclk); #1;
    want = sb.pop_front(); n_run++;
    if (w_obs !== want) begin
      n_fail++; $display("FAIL reset_resume: got %b want %b", w_obs, want);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_rr();
    test_lock();
    test_hready_stall();
    test_split();
    test_split_race();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
